mcu_cmd_sequencer: RTL and testbench

MCU_CMD_SEQUENCER -- requirements
Module: mcu_cmd_sequencer

---
 rtl/mcu_cmd_sequencer_if.sv | 23 ++
 rtl/mcu_cmd_sequencer.sv | 161 ++++++++++++++++
 tb/tb_mcu_cmd_sequencer.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/mcu_cmd_sequencer_if.sv
// MCU command sequencer memory write port.
// Write is held by the master until mem_ready is seen.
`timescale 1ns/1ps
interface mcu_cmd_sequencer_if;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_we;
  logic        mem_ready;

  modport master (
    output mem_addr,
    output mem_data,
    output mem_we,
    input  mem_ready
  );

  modport slave (
    input  mem_addr,
    input  mem_data,
    input  mem_we,
    output mem_ready
  );
endinterface

// File: rtl/mcu_cmd_sequencer.sv
// MCU byte-strobe command sequencer driving a memory write port.
// Optional macro MCU_CMD_ERR_COUNT_EN enables the saturating err_count.
`timescale 1ns/1ps
module mcu_cmd_sequencer #(
  parameter int SAMPLE_DELAY = 14
) (
  input  logic                       sysclk,
  input  logic                       rst_n,
  input  logic                       busclk,
  input  logic [7:0]                 bus,
  input  logic                       command_data,
  mcu_cmd_sequencer_if.master        mem,
  output logic                       led,
  output logic                       overflow,
  output logic                       bad_cmd,
  output logic [7:0]                 err_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR_LO,
    S_ADDR_HI,
    S_WRITE,
    S_LED_ARG
  } state_t;

  localparam logic [7:0] DLY = 8'(SAMPLE_DELAY);

  state_t      state_q;
  logic [3:0]  sync_q;
  logic [7:0]  cnt_q;
  logic        cap_v;
  logic        cap_cmd;
  logic [7:0]  cap_byte;

  logic edge_det;
  logic blocked;
  logic proc;
  logic is_cmd;
  logic is_dat;
  logic accept;
  logic ovf_evt;
  logic bad_evt;
  logic clr_evt;

  assign edge_det = (sync_q[3:1] == 3'b011);

  // Address bytes wait while a write is pending so the
  // increment of that write lands before they are applied.
  assign blocked = cap_v && !cap_cmd && mem.mem_we &&
                   (state_q == S_ADDR_LO ||
                    state_q == S_ADDR_HI);

  assign proc    = cap_v && !blocked;
  assign is_cmd  = proc && cap_cmd;
  assign is_dat  = proc && !cap_cmd;
  assign accept  = mem.mem_we && mem.mem_ready;

  assign ovf_evt = is_dat && (state_q == S_WRITE) &&
                   mem.mem_we && !mem.mem_ready;
  assign bad_evt = is_cmd && (cap_byte > 8'h04);
  assign clr_evt = is_cmd && (cap_byte == 8'h04);

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= 4'h0;
      cnt_q    <= 8'h00;
      cap_v    <= 1'b0;
      cap_cmd  <= 1'b0;
      cap_byte <= 8'h00;
    end else begin
      sync_q <= {sync_q[2:0], busclk};
      if (edge_det) begin
        cnt_q <= DLY;
      end else if (cnt_q != 8'h00) begin
        cnt_q <= cnt_q - 8'h01;
      end
      if (cnt_q == 8'h01) begin
        cap_v    <= 1'b1;
        cap_byte <= bus;
        cap_cmd  <= command_data;
      end else if (proc) begin
        cap_v <= 1'b0;
      end
    end
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      mem.mem_addr <= 16'h0000;
      mem.mem_data <= 8'h00;
      mem.mem_we   <= 1'b0;
      led          <= 1'b0;
      overflow     <= 1'b0;
      bad_cmd      <= 1'b0;
    end else begin
      if (accept) begin
        mem.mem_we   <= 1'b0;
        mem.mem_addr <= mem.mem_addr + 16'h0001;
      end
      if (ovf_evt) begin
        overflow <= 1'b1;
      end
      if (bad_evt) begin
        bad_cmd <= 1'b1;
      end
      if (clr_evt) begin
        overflow <= 1'b0;
        bad_cmd  <= 1'b0;
      end
      if (is_cmd) begin
        unique case (1'b1)
          cap_byte == 8'h01: state_q <= S_ADDR_LO;
          cap_byte == 8'h02: state_q <= S_WRITE;
          cap_byte == 8'h03: state_q <= S_LED_ARG;
          default:           state_q <= S_IDLE;
        endcase
      end else if (is_dat) begin
        unique case (state_q)
          S_ADDR_LO: begin
            mem.mem_addr[7:0] <= cap_byte;
            state_q           <= S_ADDR_HI;
          end
          S_ADDR_HI: begin
            mem.mem_addr[15:8] <= cap_byte;
            state_q            <= S_IDLE;
          end
          S_LED_ARG: begin
            led     <= cap_byte[0];
            state_q <= S_IDLE;
          end
          S_WRITE: begin
            if (!mem.mem_we || mem.mem_ready) begin
              mem.mem_we   <= 1'b1;
              mem.mem_data <= cap_byte;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

`ifdef MCU_CMD_ERR_COUNT_EN
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= 8'h00;
    end else if (clr_evt) begin
      err_count <= 8'h00;
    end else if ((ovf_evt || bad_evt) &&
                 (err_count != 8'hFF)) begin
      err_count <= err_count + 8'h01;
    end
  end
`else
  assign err_count = 8'h00;
`endif

endmodule

// File: tb/tb_mcu_cmd_sequencer.sv
// Directed bench for mcu_cmd_sequencer.
// Expected values are hand-computed constants.
`timescale 1ns/1ps
module tb_mcu_cmd_sequencer;

`ifdef MCU_CMD_ERR_COUNT_EN
  localparam bit EC = 1'b1;
`else
  localparam bit EC = 1'b0;
`endif

  logic       sysclk = 1'b0;
  logic       rst_n;
  logic       busclk;
  logic [7:0] bus;
  logic       command_data;
  logic       led;
  logic       overflow;
  logic       bad_cmd;
  logic [7:0] err_count;

  mcu_cmd_sequencer_if m ();

  mcu_cmd_sequencer #(.SAMPLE_DELAY(14)) dut (
    .sysclk       (sysclk),
    .rst_n        (rst_n),
    .busclk       (busclk),
    .bus          (bus),
    .command_data (command_data),
    .mem          (m),
    .led          (led),
    .overflow     (overflow),
    .bad_cmd      (bad_cmd),
    .err_count    (err_count)
  );

  always #5 sysclk = ~sysclk;

  logic [23:0] log_q[$];
  always @(posedge sysclk) begin
    if (rst_n && m.mem_we && m.mem_ready)
      log_q.push_back({m.mem_addr, m.mem_data});
  end

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lg(input int i);
    if (i < log_q.size())
      return {8'h00, log_q[i]};
    return 32'hDEAD_BEEF;
  endfunction

  task automatic send(input logic c, input logic [7:0] b);
    bus          = b;
    command_data = c;
    @(negedge sysclk);
    busclk = 1'b1;
    repeat (8) @(negedge sysclk);
    busclk = 1'b0;
    repeat (22) @(negedge sysclk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_addr"}, 32'(m.mem_addr), 32'h0000);
    chk({tag, "_data"}, 32'(m.mem_data), 32'h00);
    chk({tag, "_we"},   32'(m.mem_we),   32'h0);
    chk({tag, "_led"},  32'(led),        32'h0);
    chk({tag, "_ovf"},  32'(overflow),   32'h0);
    chk({tag, "_bad"},  32'(bad_cmd),    32'h0);
    chk({tag, "_err"},  32'(err_count),  32'h00);
  endtask

  initial begin
    rst_n        = 1'b0;
    busclk       = 1'b0;
    bus          = 8'h00;
    command_data = 1'b0;
    m.mem_ready  = 1'b1;
    #1;
    chk_reset_vals("rst0");
    repeat (3) @(negedge sysclk);
    rst_n = 1'b1;
    repeat (3) @(negedge sysclk);

    send(1'b1, 8'h03); send(1'b0, 8'hFF);
    chk("led_on", 32'(led), 32'h1);
    send(1'b1, 8'h03); send(1'b0, 8'h00);
    chk("led_off", 32'(led), 32'h0);

    send(1'b1, 8'h01); send(1'b0, 8'h34);
    send(1'b0, 8'h12);
    chk("set_addr", 32'(m.mem_addr), 32'h1234);
    send(1'b1, 8'h02); send(1'b0, 8'hAA);
    send(1'b0, 8'hBB);
    chk("wr_cnt1", 32'(log_q.size()), 32'd2);
    chk("wr0", lg(0), 32'h1234AA);
    chk("wr1", lg(1), 32'h1235BB);
    chk("addr_1236", 32'(m.mem_addr), 32'h1236);
    chk("we_idle", 32'(m.mem_we), 32'h0);

    send(1'b1, 8'h01); send(1'b0, 8'hFF);
    send(1'b0, 8'hFF);
    send(1'b1, 8'h02); send(1'b0, 8'h55);
    send(1'b0, 8'h66);
    chk("wr2", lg(2), 32'hFFFF55);
    chk("wr3", lg(3), 32'h000066);
    chk("addr_wrap", 32'(m.mem_addr), 32'h0001);

    m.mem_ready = 1'b0;
    send(1'b0, 8'h01); send(1'b0, 8'h02);
    chk("ovf_data", 32'(m.mem_data), 32'h01);
    chk("ovf_we", 32'(m.mem_we), 32'h1);
    chk("ovf_flag", 32'(overflow), 32'h1);
    chk("ovf_err", 32'(err_count), EC ? 32'd1 : 32'd0);
    m.mem_ready = 1'b1;
    repeat (3) @(negedge sysclk);
    chk("wr4", lg(4), 32'h000101);
    chk("addr_0002", 32'(m.mem_addr), 32'h0002);

    send(1'b1, 8'h7F);
    chk("bad_set", 32'(bad_cmd), 32'h1);
    chk("bad_err", 32'(err_count), EC ? 32'd2 : 32'd0);
    chk("bad_ovf", 32'(overflow), 32'h1);
    send(1'b1, 8'h04);
    chk("clr_bad", 32'(bad_cmd), 32'h0);
    chk("clr_ovf", 32'(overflow), 32'h0);
    chk("clr_err", 32'(err_count), 32'h00);

    m.mem_ready = 1'b0;
    send(1'b1, 8'h02); send(1'b0, 8'h77);
    send(1'b1, 8'h01); send(1'b0, 8'h10);
    chk("defer_hold", 32'(m.mem_addr), 32'h0002);
    chk("defer_we", 32'(m.mem_we), 32'h1);
    m.mem_ready = 1'b1;
    repeat (5) @(negedge sysclk);
    chk("wr5", lg(5), 32'h000277);
    chk("defer_lo", 32'(m.mem_addr), 32'h0010);
    send(1'b0, 8'h20);
    chk("defer_hi", 32'(m.mem_addr), 32'h2010);

    send(1'b1, 8'h03); send(1'b0, 8'h01);
    chk("led_pre", 32'(led), 32'h1);
    m.mem_ready = 1'b0;
    send(1'b1, 8'h02); send(1'b0, 8'h99);
    chk("pend_we", 32'(m.mem_we), 32'h1);
    chk("pend_data", 32'(m.mem_data), 32'h99);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("rst1");
    repeat (3) @(negedge sysclk);
    rst_n       = 1'b1;
    m.mem_ready = 1'b1;
    repeat (30) @(negedge sysclk);
    chk("post_we", 32'(m.mem_we), 32'h0);
    chk("post_cnt", 32'(log_q.size()), 32'd6);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
